// File: rtl/ccu_pkg.sv
// rtl/ccu_pkg.sv - shared constants for the coincidence count unit
package ccu_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_SEQ  = 3'd2;
   localparam logic [2:0] ST_PAY  = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;

endpackage

// File: rtl/count_packetizer.sv
// rtl/count_packetizer.sv - frames a snapshot of channel counts into a byte stream
module count_packetizer
   import ccu_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    snap_valid,
   input  logic [NUM_CH*CNT_W-1:0] counts,
   output logic                    busy,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    overrun,
   output logic [7:0]              drop_cnt
);

   localparam int BPC    = CNT_W / 8;
   localparam int NBYTES = NUM_CH * BPC;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   logic [2:0]          state;
   logic [NBYTES*8-1:0] snap;
   logic [NBYTES*8-1:0] ordered;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_next;
   logic [7:0]          seq;
   logic [7:0]          csum;
   logic [7:0]          next_byte;
   logic                xfer;

   // Snapshot is stored in wire order so byte k of the payload is simply snap[8k +: 8].
   always_comb begin
      ordered = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int b = 0; b < BPC; b++) begin
            ordered[(c*BPC + b)*8 +: 8] = counts[c*CNT_W + (BPC-1-b)*8 +: 8];
         end
      end
   end

   assign tx_valid  = (state != ST_IDLE);
   assign busy      = tx_valid;
   assign xfer      = tx_valid & tx_ready;
   assign idx_next  = idx + IDX_W'(1);
   assign next_byte = snap[{idx_next, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         snap     <= '0;
         idx      <= '0;
         seq      <= 8'h00;
         csum     <= 8'h00;
         tx_data  <= 8'h00;
         overrun  <= 1'b0;
         drop_cnt <= 8'h00;
      end else begin
         if (snap_valid && state != ST_IDLE) begin
            overrun <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end

         case (state)
            ST_IDLE: begin
               if (snap_valid) begin
                  snap    <= ordered;
                  tx_data <= HDR_BYTE;
                  csum    <= 8'h00;
                  idx     <= '0;
                  state   <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (xfer) begin
                  tx_data <= seq;
                  state   <= ST_SEQ;
               end
            end
            ST_SEQ: begin
               if (xfer) begin
                  csum    <= csum ^ tx_data;
                  tx_data <= snap[7:0];
                  state   <= ST_PAY;
               end
            end
            ST_PAY: begin
               if (xfer) begin
                  csum <= csum ^ tx_data;
                  if (idx == LAST_IDX) begin
                     tx_data <= csum ^ tx_data;
                     state   <= ST_CSUM;
                  end else begin
                     idx     <= idx_next;
                     tx_data <= next_byte;
                  end
               end
            end
            ST_CSUM: begin
               if (xfer) begin
                  seq   <= seq + 8'd1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_packetizer.sv
// tb/tb_count_packetizer.sv - directed self-checking bench for count_packetizer
module tb_count_packetizer;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int FLEN   = 19;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    snap_valid;
   logic [NUM_CH*CNT_W-1:0] counts;
   logic                    busy;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic                    overrun;
   logic [7:0]              drop_cnt;

   int checks = 0;
   int errors = 0;
   int pulses_left = 0;
   int rx_cyc;
   logic [7:0] fr [0:FLEN-1];
   logic [7:0] ef [0:FLEN-1];
   logic [7:0] s1 [0:FLEN-1];
   logic [127:0] cval;

   count_packetizer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid), .counts(counts),
      .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .overrun(overrun), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_exp(input logic [127:0] c, input logic [7:0] s);
      logic [7:0]  x;
      logic [31:0] w;
      x = s;
      ef[0] = 8'hA5;
      ef[1] = s;
      for (int k = 0; k < 16; k++) begin
         w = c[(k/4)*32 +: 32];
         ef[2+k] = 8'(w >> (8*(3 - (k%4))));
         x = x ^ ef[2+k];
      end
      ef[18] = x;
   endtask

   task automatic cmp_frame(input string tag);
      for (int i = 0; i < FLEN; i++) chk($sformatf("%s_b%0d", tag, i), 32'(fr[i]), 32'(ef[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; snap_valid = 1'b0; tx_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge; leaves the bench at the negedge where the header is offered.
   task automatic start_frame(input logic [127:0] c, input string tag);
      counts = c; snap_valid = 1'b1;
      @(negedge clk);
      snap_valid = 1'b0;
      chk({tag, "_hdr_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_hdr_data"}, 32'(tx_data), 32'hA5);
   endtask

   // mode 0: tx_ready held high, mode 1: random; drop: pulse snap_valid while busy.
   task automatic rx_frame(input int mode, input bit drop, input int nbytes, input string tag);
      int n, cyc;
      bit rdy, hold;
      logic [7:0] prev;
      n = 0; cyc = 0; hold = 0; prev = 8'h00;
      while (n < nbytes && cyc < 2000) begin
         if (hold) begin
            chk({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(tx_data), 32'(prev));
         end
         rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         tx_ready = rdy;
         if (drop && busy && pulses_left > 0) begin
            snap_valid = 1'b1;
            counts = {$urandom, $urandom, $urandom, $urandom};
            pulses_left--;
         end else begin
            snap_valid = 1'b0;
         end
         if (tx_valid && rdy) begin
            fr[n] = tx_data;
            n++;
         end
         hold = tx_valid && !rdy;
         prev = tx_data;
         @(negedge clk);
         cyc++;
      end
      tx_ready = 1'b0;
      snap_valid = 1'b0;
      rx_cyc = cyc;
      chk({tag, "_nbytes"}, 32'(n), 32'(nbytes));
   endtask

   initial begin
      counts = '0;
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Scenario 1: hand-computed stream, tx_ready held high
      s1[0] = 8'hA5; s1[1] = 8'h00; s1[18] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         s1[2+i] = 8'h11; s1[6+i] = 8'h22; s1[10+i] = 8'h33; s1[14+i] = 8'h44;
      end
      cval = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      start_frame(cval, "s1");
      rx_frame(0, 1'b0, FLEN, "s1");
      for (int i = 0; i < FLEN; i++) chk($sformatf("s1_b%0d", i), 32'(fr[i]), 32'(s1[i]));
      chk("s1_consecutive", 32'(rx_cyc), 32'd19);
      chk("s1_busy_after", 32'(busy), 32'd0);

      // Scenario 2: same stream under random back-pressure
      do_reset();
      @(negedge clk);
      start_frame(cval, "s2");
      rx_frame(1, 1'b0, FLEN, "s2");
      for (int i = 0; i < FLEN; i++) chk($sformatf("s2_b%0d", i), 32'(fr[i]), 32'(s1[i]));
      chk("s2_busy_after", 32'(busy), 32'd0);

      // Scenario 3 (+6): 257 back-to-back frames; seq FF frame carries all-FF counts
      do_reset();
      @(negedge clk);
      for (int f = 0; f < 257; f++) begin
         cval = (f == 255) ? {128{1'b1}} : {$urandom, $urandom, $urandom, $urandom};
         start_frame(cval, "s3");
         rx_frame(0, 1'b0, FLEN, "s3");
         build_exp(cval, 8'(f));
         cmp_frame($sformatf("s3_f%0d", f));
         if (f == 255) begin
            chk("s6_seq", 32'(fr[1]), 32'hFF);
            chk("s6_csum", 32'(fr[18]), 32'hFF);
         end
         if (f == 256) chk("s3_seq_wrap", 32'(fr[1]), 32'h00);
      end
      chk("s3_overrun_clear", 32'(overrun), 32'd0);

      // Scenario 4: 300 snap pulses while busy, including CSUM cycles
      pulses_left = 300;
      for (int f = 0; f < 20 && pulses_left > 0; f++) begin
         cval = {$urandom, $urandom, $urandom, $urandom};
         start_frame(cval, "s4");
         rx_frame(0, 1'b1, FLEN, "s4");
         build_exp(cval, 8'(257 + f));
         cmp_frame($sformatf("s4_f%0d", f));
         if (f == 0) begin
            chk("s4_drop_first", 32'(drop_cnt), 32'd19);
            chk("s4_overrun_first", 32'(overrun), 32'd1);
         end
      end
      chk("s4_pulses_used", 32'(pulses_left), 32'd0);
      chk("s4_overrun", 32'(overrun), 32'd1);
      chk("s4_drop_sat", 32'(drop_cnt), 32'hFF);

      // Scenario 5: reset while the 7th byte is offered
      cval = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      start_frame(cval, "s5");
      rx_frame(0, 1'b0, 6, "s5");
      chk("s5_byte7_offered", 32'(tx_data), 32'h22);
      rst_n = 1'b0; tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("s5_valid", 32'(tx_valid), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_data", 32'(tx_data), 32'h00);
      chk("s5_overrun", 32'(overrun), 32'd0);
      chk("s5_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      start_frame(cval, "s5n");
      rx_frame(0, 1'b0, FLEN, "s5n");
      chk("s5_next_hdr", 32'(fr[0]), 32'hA5);
      chk("s5_next_seq", 32'(fr[1]), 32'h00);
      for (int i = 2; i < FLEN; i++) chk($sformatf("s5n_b%0d", i), 32'(fr[i]), 32'(s1[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
